// File: rtl/sort_frame_collector.sv
// sort_frame_collector: gathers a nibble stream into a 5-slot frame for the bubble sorter.
// Short frames (in_last) are padded with PAD; the frame is held until the consumer accepts.
`default_nettype none

module sort_frame_collector #(
    parameter int                 WIDTH = 4,
    parameter logic [WIDTH-1:0]   PAD   = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [2:0]       frame_len,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       idx;
    logic [WIDTH-1:0] slot [0:4];
    logic             frame_done;

    // A fifth element closes the frame whether or not in_last accompanies it.
    assign frame_done = (idx == 3'd4) || in_last;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            idx       <= 3'd0;
            frame_len <= 3'd0;
            for (int i = 0; i < 5; i++) begin
                slot[i] <= {WIDTH{1'b0}};
            end
        end else begin
            case (state)
                IDLE: state <= FILL;
                FILL: begin
                    if (clear) begin
                        idx <= 3'd0;
                    end else if (in_valid) begin
                        for (int i = 0; i < 5; i++) begin
                            if (3'(i) == idx) begin
                                slot[i] <= in_data;
                            end else if (frame_done && (3'(i) > idx)) begin
                                slot[i] <= PAD;
                            end
                        end
                        if (frame_done) begin
                            frame_len <= idx + 3'd1;
                            idx       <= 3'd0;
                            state     <= FULL;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                FULL: begin
                    // clear wins over out_ready; both return to FILL with an empty index.
                    if (clear) begin
                        idx   <= 3'd0;
                        state <= FILL;
                    end else if (out_ready) begin
                        state <= FILL;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == FILL);
    assign out_valid = (state == FULL);
    assign out0      = slot[0];
    assign out1      = slot[1];
    assign out2      = slot[2];
    assign out3      = slot[3];
    assign out4      = slot[4];

endmodule

`default_nettype wire

// File: tb/tb_sort_frame_collector.sv
// Testbench for sort_frame_collector: scoreboard of expected frames, one task per scenario.
`default_nettype none

module tb_sort_frame_collector;

    localparam int         WIDTH = 4;
    localparam logic [3:0] PAD   = 4'b0000;

    typedef struct packed {
        logic [4:0][3:0] s;
        logic [2:0]      len;
    } frame_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out0, out1, out2, out3, out4;
    logic [2:0] frame_len;

    sort_frame_collector #(.WIDTH(WIDTH), .PAD(PAD)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .frame_len (frame_len),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 CLK = ~CLK;

    int              n_checks = 0;
    int              n_fail   = 0;
    frame_t          sb[$];
    logic [4:0][3:0] cur;
    int              cur_n = 0;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Drive one element, wait for acceptance, and feed the reference frame builder.
    task automatic send(input logic [3:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int w = 0; !in_ready && w < 20; w++) step();
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%0b, required 1", in_ready);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        step();
        cur[cur_n] = d;
        cur_n++;
        if (last || cur_n == 5) begin
            for (int i = cur_n; i < 5; i++) cur[i] = PAD;
            sb.push_back({cur, 3'(cur_n)});
            cur_n = 0;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic collect(output frame_t got, output frame_t exp);
        for (int w = 0; !out_valid && w < 20; w++) step();
        if (!out_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL out_valid_timeout: out_valid=%0b, required 1", out_valid);
        end
        got = {out4, out3, out2, out1, out0, frame_len};
        exp = (sb.size() > 0) ? sb.pop_front() : '1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        frame_t got, exp;
        RST = 1'b1;
        step();
        step();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: out_valid,in_ready=%b, required 00", {out_valid, in_ready});
        end
        got = {out4, out3, out2, out1, out0, frame_len};
        exp = '0;
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_frame: got %h, required %h", got, exp);
        end
        RST = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_hold: in_ready=%b, required 0", in_ready);
        end
        step();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_to_fill: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_full_frame();
        frame_t got, exp;
        send(4'd0, 1'b0);
        send(4'd5, 1'b0);
        send(4'd1, 1'b0);
        send(4'd3, 1'b0);
        send(4'd6, 1'b0);
        n_checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL full_latency: out_valid,in_ready=%b, required 10", {out_valid, in_ready});
        end
        collect(got, exp);
        n_checks++;
        if (got !== exp || exp.len !== 3'd5) begin
            n_fail++;
            $display("FAIL full_frame: got %h, required %h", got, exp);
        end
        for (int c = 0; c < 10; c++) begin
            step();
            n_checks++;
            if ({out4, out3, out2, out1, out0, frame_len, out_valid, in_ready} !== {exp, 2'b10}) begin
                n_fail++;
                $display("FAIL full_hold cycle %0d: got %h, required %h", c,
                         {out4, out3, out2, out1, out0, frame_len, out_valid, in_ready}, {exp, 2'b10});
            end
        end
        consume();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL full_release: out_valid,in_ready=%b, required 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_short_frame();
        frame_t got, exp;
        send(4'd9, 1'b0);
        send(4'd2, 1'b1);
        collect(got, exp);
        n_checks++;
        if (got !== exp || exp.len !== 3'd2) begin
            n_fail++;
            $display("FAIL short_frame: got %h, required %h", got, exp);
        end
        consume();
        send(4'd11, 1'b1);
        collect(got, exp);
        n_checks++;
        if (got !== exp || exp.len !== 3'd1) begin
            n_fail++;
            $display("FAIL single_frame: got %h, required %h", got, exp);
        end
        consume();
    endtask

    task automatic test_backpressure();
        frame_t got, exp;
        logic [3:0] vals [5] = '{4'd7, 4'd7, 4'd4, 4'd15, 4'd1};
        for (int k = 0; k < 5; k++) begin
            // in_last floats high during gaps and must be ignored without in_valid.
            in_last = 1'b1;
            repeat ($urandom_range(0, 3)) step();
            in_last = 1'b0;
            send(vals[k], 1'b0);
        end
        collect(got, exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL gap_frame: got %h, required %h", got, exp);
        end
        in_valid = 1'b1;
        in_data  = 4'd8;
        repeat (3) step();
        in_valid = 1'b0;
        n_checks++;
        if ({out4, out3, out2, out1, out0, frame_len, out_valid} !== {exp, 1'b1}) begin
            n_fail++;
            $display("FAIL full_ignores_input: got %h, required %h",
                     {out4, out3, out2, out1, out0, frame_len, out_valid}, {exp, 1'b1});
        end
        consume();
        send(4'd3, 1'b1);
        collect(got, exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL after_full_frame: got %h, required %h", got, exp);
        end
        consume();
    endtask

    task automatic test_clear();
        frame_t got, exp;
        send(4'd1, 1'b0);
        send(4'd2, 1'b0);
        send(4'd3, 1'b0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd9;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        cur_n    = 0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL clear_fill: out_valid,in_ready=%b, required 01", {out_valid, in_ready});
        end
        for (int k = 0; k < 5; k++) send(4'(k + 4), 1'b0);
        collect(got, exp);
        n_checks++;
        if (got !== exp || exp.len !== 3'd5) begin
            n_fail++;
            $display("FAIL clear_fresh_frame: got %h, required %h", got, exp);
        end
        clear     = 1'b1;
        out_ready = 1'b1;
        step();
        clear     = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready, frame_len} !== {2'b01, 3'd5}) begin
            n_fail++;
            $display("FAIL clear_in_full: got %b, required %b", {out_valid, in_ready, frame_len}, {2'b01, 3'd5});
        end
    endtask

    task automatic test_reset_mid();
        frame_t got, exp;
        send(4'd10, 1'b0);
        send(4'd11, 1'b1);
        collect(got, exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL pre_reset_frame: got %h, required %h", got, exp);
        end
        #3;
        RST = 1'b1;
        #1;
        n_checks++;
        if ({out4, out3, out2, out1, out0, frame_len, out_valid, in_ready} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %h, required 0",
                     {out4, out3, out2, out1, out0, frame_len, out_valid, in_ready});
        end
        #2;
        RST = 1'b0;
        step();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b, required 1", in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_frame();
        test_backpressure();
        test_clear();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d frames left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
